// File: rtl/wb_bist_pkg.sv
// Shared types and constants for the Wishbone SDRAM BIST master.
//   state_e : controller FSM states
//   mode_e  : data pattern selection
//   CTI_*   : Wishbone cycle type codes
//   LFSR_*  : pattern LFSR seed and Galois feedback mask
package wb_bist_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WR_BURST  = 3'd2,
        WR_GAP    = 3'd3,
        RD_BURST  = 3'd4,
        RD_GAP    = 3'd5,
        DONE      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        MODE_INDEX     = 2'd0,
        MODE_WALK1     = 2'd1,
        MODE_LFSR      = 2'd2,
        MODE_INV_INDEX = 2'd3
    } mode_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/wb_bist_patgen.sv
// Test pattern generator: one registered word per global beat index.
//   clk, rst_n : clock, async active-low reset
//   mode       : pattern select (held stable during a test)
//   restart    : next word is beat 0 of the pattern
//   advance    : next word is the following beat
//   word       : current expected / write data word
module wb_bist_patgen
    import wb_bist_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  mode_e         mode,
    input  logic          restart,
    input  logic          advance,
    output logic [DW-1:0] word
);

    localparam int unsigned SW = (DW > 1) ? $clog2(DW) : 1;

    logic [31:0] k_q, k_n;
    logic [31:0] lfsr_q, lfsr_n;

    function automatic logic [DW-1:0] pattern(input mode_e m, input logic [31:0] k,
                                              input logic [31:0] l);
        case (m)
            MODE_INDEX: return DW'(k);
            MODE_WALK1: return DW'(1) << k[SW-1:0];
            MODE_LFSR:  return DW'(l);
            default:    return ~DW'(k);
        endcase
    endfunction

    // Beat index and LFSR state for the word that follows
    always_comb begin
        k_n    = k_q;
        lfsr_n = lfsr_q;
        if (restart) begin
            k_n    = 32'd0;
            lfsr_n = LFSR_SEED;
        end else if (advance) begin
            k_n    = k_q + 32'd1;
            lfsr_n = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            lfsr_q <= '0;
            word   <= '0;
        end else begin
            k_q    <= k_n;
            lfsr_q <= lfsr_n;
            if (restart || advance) word <= pattern(mode, k_n, lfsr_n);
        end
    end

endmodule

// File: rtl/wb_sdram_bist.sv
// Wishbone master BIST: writes a pattern over a region in incrementing
// bursts, reads it back, counts mismatches, aborts on an ack watchdog.
//   wb_clk_i, wb_rst_n_i      : clock, async active-low reset
//   start_i, mode_i, base_addr_i : test launch and configuration
//   sdr_init_done_i           : controller ready
//   wb_*                      : Wishbone master port (byte addressed)
//   busy_o, done_o, pass_o, timeout_o, err_cnt_o, first_err_addr_o : status
module wb_sdram_bist
    import wb_bist_pkg::*;
#(
    parameter int unsigned APP_AW     = 26,
    parameter int unsigned APP_DW     = 32,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned NUM_BURSTS = 16,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [APP_AW-1:0]     base_addr_i,
    input  logic                  sdr_init_done_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [APP_AW-1:0]     wb_addr_o,
    output logic [APP_DW-1:0]     wb_dat_o,
    output logic [APP_DW/8-1:0]   wb_sel_o,
    output logic [2:0]            wb_cti_o,
    input  logic                  wb_ack_i,
    input  logic [APP_DW-1:0]     wb_dat_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_cnt_o,
    output logic [APP_AW-1:0]     first_err_addr_o
);

    localparam int unsigned BYTES  = APP_DW / 8;
    localparam int unsigned BEAT_W = 4;
    localparam int unsigned BCNT_W = 12;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    state_e              state_q, state_n;
    mode_e               mode_q, mode_n;
    logic [APP_AW-1:0]   base_q, base_n;
    logic [BEAT_W-1:0]   beat_q, beat_n;
    logic [BCNT_W-1:0]   burst_q, burst_n;
    logic [WD_W-1:0]     wd_q, wd_n;
    logic                cyc_n, stb_n, we_n;
    logic [APP_AW-1:0]   addr_n, ferr_n;
    logic [2:0]          cti_n;
    logic                busy_n, done_n, pass_n, timeout_n;
    logic [15:0]         err_n;
    logic                pat_restart, pat_advance;

    function automatic logic [2:0] cti_of(input logic [BEAT_W-1:0] b);
        if (BURST_LEN == 1) return CTI_CLASSIC;
        return (b == BEAT_W'(BURST_LEN - 1)) ? CTI_EOB : CTI_INCR;
    endfunction

    wb_bist_patgen #(.DW(APP_DW)) u_patgen (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .mode    (mode_q),
        .restart (pat_restart),
        .advance (pat_advance),
        .word    (wb_dat_o)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= IDLE;
        else             state_q <= state_n;
    end

    // Next state and next value of every registered output
    always_comb begin
        state_n     = state_q;
        mode_n      = mode_q;
        base_n      = base_q;
        beat_n      = beat_q;
        burst_n     = burst_q;
        wd_n        = '0;
        cyc_n       = wb_cyc_o;
        stb_n       = wb_stb_o;
        we_n        = wb_we_o;
        addr_n      = wb_addr_o;
        cti_n       = wb_cti_o;
        busy_n      = busy_o;
        done_n      = done_o;
        pass_n      = pass_o;
        timeout_n   = timeout_o;
        err_n       = err_cnt_o;
        ferr_n      = first_err_addr_o;
        pat_restart = 1'b0;
        pat_advance = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n   = WAIT_INIT;
                    mode_n    = mode_e'(mode_i);
                    base_n    = base_addr_i;
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                    pass_n    = 1'b0;
                    timeout_n = 1'b0;
                    err_n     = '0;
                    ferr_n    = '0;
                end
            end
            WAIT_INIT: begin
                if (sdr_init_done_i) begin
                    state_n     = WR_BURST;
                    pat_restart = 1'b1;
                    beat_n      = '0;
                    burst_n     = '0;
                    addr_n      = base_q;
                    cyc_n       = 1'b1;
                    stb_n       = 1'b1;
                    we_n        = 1'b1;
                    cti_n       = cti_of('0);
                end
            end
            WR_BURST, RD_BURST: begin
                if (wb_stb_o && !wb_ack_i) begin
                    wd_n = wd_q + WD_W'(1);
                    if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        state_n   = DONE;
                        wd_n      = '0;
                        cyc_n     = 1'b0;
                        stb_n     = 1'b0;
                        we_n      = 1'b0;
                        cti_n     = CTI_CLASSIC;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                        pass_n    = 1'b0;
                        timeout_n = 1'b1;
                    end
                end else if (wb_stb_o && wb_ack_i) begin
                    pat_advance = 1'b1;
                    addr_n      = wb_addr_o + APP_AW'(BYTES);
                    if (state_q == RD_BURST && wb_dat_i != wb_dat_o) begin
                        if (err_cnt_o == 16'h0)    ferr_n = wb_addr_o;
                        if (err_cnt_o != 16'hFFFF) err_n  = err_cnt_o + 16'd1;
                    end
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        beat_n = '0;
                        cyc_n  = 1'b0;
                        stb_n  = 1'b0;
                        cti_n  = CTI_CLASSIC;
                        if (state_q == WR_BURST) begin
                            state_n = WR_GAP;
                        end else if (burst_q == BCNT_W'(NUM_BURSTS - 1)) begin
                            state_n = DONE;
                            we_n    = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pass_n  = (err_n == 16'h0) && !timeout_o;
                        end else begin
                            state_n = RD_GAP;
                        end
                    end else begin
                        beat_n = beat_q + BEAT_W'(1);
                        cti_n  = cti_of(beat_q + BEAT_W'(1));
                    end
                end
            end
            WR_GAP: begin
                cyc_n = 1'b1;
                stb_n = 1'b1;
                cti_n = cti_of('0);
                if (burst_q == BCNT_W'(NUM_BURSTS - 1)) begin
                    // Read phase replays the region from the base
                    state_n     = RD_BURST;
                    burst_n     = '0;
                    addr_n      = base_q;
                    we_n        = 1'b0;
                    pat_restart = 1'b1;
                end else begin
                    state_n = WR_BURST;
                    burst_n = burst_q + BCNT_W'(1);
                    we_n    = 1'b1;
                end
            end
            RD_GAP: begin
                state_n = RD_BURST;
                burst_n = burst_q + BCNT_W'(1);
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
                we_n    = 1'b0;
                cti_n   = cti_of('0);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mode_q           <= MODE_INDEX;
            base_q           <= '0;
            beat_q           <= '0;
            burst_q          <= '0;
            wd_q             <= '0;
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
            wb_we_o          <= 1'b0;
            wb_addr_o        <= '0;
            wb_sel_o         <= '0;
            wb_cti_o         <= CTI_CLASSIC;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
        end else begin
            mode_q           <= mode_n;
            base_q           <= base_n;
            beat_q           <= beat_n;
            burst_q          <= burst_n;
            wd_q             <= wd_n;
            wb_cyc_o         <= cyc_n;
            wb_stb_o         <= stb_n;
            wb_we_o          <= we_n;
            wb_addr_o        <= addr_n;
            wb_sel_o         <= '1;
            wb_cti_o         <= cti_n;
            busy_o           <= busy_n;
            done_o           <= done_n;
            pass_o           <= pass_n;
            timeout_o        <= timeout_n;
            err_cnt_o        <= err_n;
            first_err_addr_o <= ferr_n;
        end
    end

endmodule

// File: tb/tb_wb_sdram_bist.sv
// Bench for wb_sdram_bist: Wishbone memory slave plus a scoreboard of
// expected beats (address, write data, cycle type) built from a pattern model.
module tb_wb_sdram_bist;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int BL    = 4;
    localparam int NB    = 16;
    localparam int TO    = 256;
    localparam int BEATS = BL * NB;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    cti;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start1 = 1'b0;
    logic          init_done = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] base = '0;

    logic          cyc, stb, we, ack = 1'b0;
    logic [AW-1:0] addr, ferr;
    logic [DW-1:0] dat_o, dat_i = '0;
    logic [DW/8-1:0] sel;
    logic [2:0]    cti;
    logic          busy, done, pass, tmo;
    logic [15:0]   err;

    logic          cyc1, stb1, we1, ack1 = 1'b0;
    logic [AW-1:0] addr1, ferr1;
    logic [DW-1:0] dat1_o, dat1_i = '0;
    logic [DW/8-1:0] sel1;
    logic [2:0]    cti1;
    logic          busy1, done1, pass1, tmo1;
    logic [15:0]   err1;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t sb[$];
    logic [DW-1:0] mem[logic [AW-1:0]];
    logic [DW-1:0] mem1[logic [AW-1:0]];
    int  wr_acks, rd_acks, fault_at, stb_cycles, b1_acks;
    bit  ack_en = 1'b1;
    bit  seen_cyc;
    int  gap_run, gap_min, gap_max;

    wb_sdram_bist #(.APP_AW(AW), .APP_DW(DW), .BURST_LEN(BL), .NUM_BURSTS(NB), .TIMEOUT(TO)) u_dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .mode_i(mode),
        .base_addr_i(base), .sdr_init_done_i(init_done),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr),
        .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_cti_o(cti),
        .wb_ack_i(ack), .wb_dat_i(dat_i),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .err_cnt_o(err), .first_err_addr_o(ferr)
    );

    wb_sdram_bist #(.APP_AW(AW), .APP_DW(DW), .BURST_LEN(1), .NUM_BURSTS(4), .TIMEOUT(TO)) u_dut_b1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start1), .mode_i(2'd2),
        .base_addr_i(26'h40), .sdr_init_done_i(1'b1),
        .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_we_o(we1), .wb_addr_o(addr1),
        .wb_dat_o(dat1_o), .wb_sel_o(sel1), .wb_cti_o(cti1),
        .wb_ack_i(ack1), .wb_dat_i(dat1_i),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .timeout_o(tmo1),
        .err_cnt_o(err1), .first_err_addr_o(ferr1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [DW-1:0] model_pat(input logic [1:0] m, input int k, input logic [31:0] l);
        logic [DW-1:0] one;
        one = 1;
        case (m)
            2'd0:    return DW'(k);
            2'd1:    return one << (k % DW);
            2'd2:    return l[DW-1:0];
            default: return ~DW'(k);
        endcase
    endfunction

    // Expected write beats then read beats of one full test
    task automatic push_run(input logic [1:0] m, input logic [AW-1:0] b);
        beat_t e;
        logic [31:0] l;
        for (int ph = 0; ph < 2; ph++) begin
            l = 32'hACE1_0001;
            for (int k = 0; k < BEATS; k++) begin
                e.we   = (ph == 0);
                e.addr = AW'(32'(b) + 32'(k * (DW / 8)));
                e.data = model_pat(m, k, l);
                e.cti  = ((k % BL) == BL - 1) ? 3'b111 : 3'b010;
                sb.push_back(e);
                l = model_lfsr(l);
            end
        end
    endtask

    // Wishbone slave: acks every other cycle, checks each beat against the scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            ack = 1'b0;
        end else if (cyc && stb && !ack && ack_en) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("we", we, e.we);
                check_eq("addr", addr, e.addr);
                check_eq("cti", cti, e.cti);
                if (we) begin
                    check_eq("wdata", dat_o, e.data);
                    mem[addr] = dat_o;
                    wr_acks++;
                end else begin
                    rd_acks++;
                    dat_i = mem.exists(addr) ? mem[addr] : '0;
                    if (rd_acks == fault_at) dat_i[0] = ~dat_i[0];
                end
            end
            ack = 1'b1;
        end else begin
            ack = 1'b0;
        end
        if (stb) stb_cycles++;
        if (busy) begin
            if (cyc) begin
                if (gap_run > 0) begin
                    if (gap_run < gap_min) gap_min = gap_run;
                    if (gap_run > gap_max) gap_max = gap_run;
                    gap_run = 0;
                end
                seen_cyc = 1'b1;
            end else if (seen_cyc) begin
                gap_run++;
            end
        end
    end

    // Echo slave for the single-beat instance
    always @(negedge clk) begin
        if (!rst_n) begin
            ack1 = 1'b0;
        end else if (cyc1 && stb1 && !ack1) begin
            check_eq("b1_cti", cti1, 3'b000);
            if (we1) mem1[addr1] = dat1_o;
            else     dat1_i = mem1.exists(addr1) ? mem1[addr1] : '0;
            b1_acks++;
            ack1 = 1'b1;
        end else begin
            ack1 = 1'b0;
        end
    end

    task automatic clear_stats();
        wr_acks = 0; rd_acks = 0; stb_cycles = 0; fault_at = -1;
        seen_cyc = 1'b0; gap_run = 0; gap_min = 1000; gap_max = 0;
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [AW-1:0] b);
        @(negedge clk);
        mode = m; base = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_within_budget", done, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wb"}, {cyc, stb, we, addr, cti, sel}, 0);
        check_eq({tag, "_dat"}, dat_o, 0);
        check_eq({tag, "_status"}, {busy, done, pass, tmo, err, ferr}, 0);
    endtask

    task automatic check_run_end(input string tag, input bit exp_pass, input int exp_err,
                                 input logic [AW-1:0] exp_ferr);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_pass"}, pass, exp_pass);
        check_eq({tag, "_timeout"}, tmo, 0);
        check_eq({tag, "_err_cnt"}, err, 16'(exp_err));
        check_eq({tag, "_first_err"}, ferr, exp_ferr);
        check_eq({tag, "_wr_acks"}, wr_acks, BEATS);
        check_eq({tag, "_rd_acks"}, rd_acks, BEATS);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
        check_eq({tag, "_gap_min"}, gap_min, 1);
        check_eq({tag, "_gap_max"}, gap_max, 1);
        check_eq({tag, "_cyc_idle"}, cyc, 0);
    endtask

    task automatic full_run(input string tag, input logic [1:0] m, input logic [AW-1:0] b,
                            input int fault, input bit exp_pass, input int exp_err,
                            input logic [AW-1:0] exp_ferr);
        clear_stats();
        fault_at = fault;
        sb.delete();
        push_run(m, b);
        pulse_start(m, b);
        check_eq({tag, "_busy_after_start"}, busy, 1);
        wait_done(3000);
        check_run_end(tag, exp_pass, exp_err, exp_ferr);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int c;
        bit stb_seen;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("sel_after_reset", sel, 4'hF);

        full_run("pass_m0", 2'd0, '0, -1, 1'b1, 0, '0);
        full_run("pass_m1_wrap", 2'd1, 26'h3FF_FFF0, -1, 1'b1, 0, '0);
        full_run("pass_m3", 2'd3, 26'h0000_100, -1, 1'b1, 0, '0);
        full_run("fault_m2", 2'd2, '0, 5, 1'b0, 1, 26'd16);

        // Watchdog: slave never acks
        clear_stats();
        sb.delete();
        ack_en = 1'b0;
        pulse_start(2'd0, '0);
        wait_done(1000);
        check_eq("wd_stb_cycles", stb_cycles, TO);
        check_eq("wd_cyc_stb", {cyc, stb}, 2'b00);
        check_eq("wd_timeout", tmo, 1);
        check_eq("wd_pass", pass, 0);
        check_eq("wd_busy", busy, 0);
        ack_en = 1'b1;

        // Restart from DONE clears the watchdog flag
        clear_stats();
        sb.delete();
        push_run(2'd2, 26'h200);
        pulse_start(2'd2, 26'h200);
        check_eq("restart_timeout_clear", tmo, 0);
        check_eq("restart_done_clear", done, 0);
        wait_done(3000);
        check_run_end("after_wd", 1'b1, 0, '0);

        // Start gating and init wait
        clear_stats();
        sb.delete();
        init_done = 1'b0;
        push_run(2'd1, 26'h80);
        pulse_start(2'd1, 26'h80);
        stb_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                mode = 2'd3; base = 26'h1000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (stb || cyc) stb_seen = 1'b1;
            @(negedge clk);
        end
        check_eq("no_stb_before_init", stb_seen, 0);
        check_eq("busy_waiting_init", busy, 1);
        init_done = 1'b1;
        repeat (30) @(negedge clk);
        mode = 2'd0; base = 26'h2000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        check_run_end("gating", 1'b1, 0, '0);

        // Asynchronous reset during write beat 2
        clear_stats();
        sb.delete();
        push_run(2'd0, '0);
        pulse_start(2'd0, '0);
        c = 0;
        while (wr_acks < 2 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_eq("reached_beat2", wr_acks, 2);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_after_reset", {busy, done, cyc, stb}, 4'b0000);
        full_run("after_reset", 2'd0, '0, -1, 1'b1, 0, '0);

        // Single-beat bursts use classic cycles
        b1_acks = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        c = 0;
        while (!done1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check_eq("b1_done", done1, 1);
        check_eq("b1_pass", pass1, 1);
        check_eq("b1_err", err1, 0);
        check_eq("b1_acks", b1_acks, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
